// File: rtl/mnist_nn_pio_pkg.sv
// Shared constants for the key PIO: register map, edge-capture modes and
// the edge qualification helper.
package mnist_nn_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // True when the prev->cur transition of one debounced bit matches the mode.
   function automatic logic edge_hit(input int mode, input logic prev_lvl,
                                     input logic cur_lvl);
      case (mode)
         EDGE_RISE: return !prev_lvl && cur_lvl;
         EDGE_FALL: return prev_lvl && !cur_lvl;
         default:   return prev_lvl ^ cur_lvl;
      endcase
   endfunction

endpackage

// File: rtl/mnist_nn_key_pio_if.sv
// Avalon-MM slave bus of the key PIO plus its level interrupt.
interface mnist_nn_key_pio_if;

   // Handshake: a write is accepted on every clk edge where chipselect = 1 and
   // write_n = 0 (no wait states); reads need no strobe, readdata always shows
   // the register at the address presented one edge earlier.
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, chipselect, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, write_n, writedata,
                   output readdata, irq);

endinterface

// File: rtl/mnist_nn_key_debounce.sv
// One-bit key debouncer fed by the synchronizer output. Counter-based filter
// when MNIST_NN_KEY_PIO_DEBOUNCE_EN is defined, otherwise a single register.
module mnist_nn_key_debounce #(
`ifdef MNIST_NN_KEY_PIO_DEBOUNCE_EN
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
`endif
   parameter logic        IDLE_BIT        = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_bit,
   output logic deb_bit
);

`ifdef MNIST_NN_KEY_PIO_DEBOUNCE_EN
   logic [15:0] cnt;

   // Any cycle where the input agrees with the held level restarts the count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt     <= 16'd0;
         deb_bit <= IDLE_BIT;
      end else if (sync_bit == deb_bit) begin
         cnt <= 16'd0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
         cnt     <= 16'd0;
         deb_bit <= sync_bit;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!reset_n) deb_bit <= IDLE_BIT;
      else          deb_bit <= sync_bit;
   end
`endif

endmodule

// File: rtl/mnist_nn_key_pio.sv
// Key PIO: 2-flop synchronizer, per-bit debouncer (MNIST_NN_KEY_PIO_DEBOUNCE_EN),
// edge capture with write-1-to-clear, interrupt mask and Avalon-MM readback.
module mnist_nn_key_pio
   import mnist_nn_pio_pkg::*;
#(
   parameter int          WIDTH           = 4,
   parameter int          EDGE_TYPE       = 1,
   parameter int          IDLE_LEVEL      = 1,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic              clk,
   input  logic              reset_n,
   mnist_nn_key_pio_if.slave bus,
   input  logic [WIDTH-1:0]  in_port
);

   localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? '1 : '0;

   logic [WIDTH-1:0] sync1, sync_q, deb_q, deb_prev;
   logic [WIDTH-1:0] irq_mask, edge_cap, edge_set, cap_clr, rd_val;
   logic [31:0]      rd_word;
   logic             wr_en;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1  <= IDLE_VEC;
         sync_q <= IDLE_VEC;
      end else begin
         sync1  <= in_port;
         sync_q <= sync1;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_deb
      mnist_nn_key_debounce #(
`ifdef MNIST_NN_KEY_PIO_DEBOUNCE_EN
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
         .IDLE_BIT        (IDLE_VEC[g])
      ) u_deb (
         .clk      (clk),
         .reset_n  (reset_n),
         .sync_bit (sync_q[g]),
         .deb_bit  (deb_q[g])
      );
   end

   always_comb begin
      edge_set = '0;
      for (int i = 0; i < WIDTH; i++) edge_set[i] = edge_hit(EDGE_TYPE, deb_prev[i], deb_q[i]);
   end

   assign wr_en   = bus.chipselect && !bus.write_n;
   assign cap_clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_val = '0;
      case (bus.address)
         ADDR_DATA:    rd_val = deb_q;
         ADDR_IRQMASK: rd_val = irq_mask;
         ADDR_EDGECAP: rd_val = edge_cap;
         default:      rd_val = '0;
      endcase
      rd_word              = '0;
      rd_word[WIDTH-1:0]   = rd_val;
   end

   // deb_prev resets to the idle level so release never looks like an edge;
   // the set term is ORed last so a same-cycle capture beats the clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deb_prev     <= IDLE_VEC;
         irq_mask     <= '0;
         edge_cap     <= '0;
         bus.readdata <= 32'd0;
      end else begin
         deb_prev     <= deb_q;
         edge_cap     <= (edge_cap & ~cap_clr) | edge_set;
         bus.readdata <= rd_word;
         if (wr_en && bus.address == ADDR_IRQMASK) irq_mask <= bus.writedata[WIDTH-1:0];
      end
   end

   assign bus.irq = |(edge_cap & irq_mask);

   if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
   end

endmodule

// File: doc/mnist_nn_key_pio.md
MNIST_NN_KEY_PIO -- requirements
Module: mnist_nn_key_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of key inputs, 1..32.
REQ-002 SHALL have parameter EDGE_TYPE, default 1: edge-capture mode, 0 = rising, 1 = falling, 2 = any.
REQ-003 SHALL have parameter IDLE_LEVEL, default 1: per-bit reset value of the synchronizer and debounced level; 1 means all-ones.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000: required stable interval, 2..65535.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1 bit: reset that is synchronous and active-low; all state is cleared on a clk rising edge while reset_n = 0.
REQ-007 SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1 bit: slave select.
REQ-009 SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-010 SHALL have port writedata, input, 32 bits: write data.
REQ-011 SHALL have port in_port, input, WIDTH bits: asynchronous key levels.
REQ-012 SHALL have port readdata, output, 32 bits: registered read data.
REQ-013 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-014 SHALL pass each in_port bit through a 2-flop synchronizer; sync_q is valid 2 clk edges after the input settles.
REQ-015 SHALL define the register map as follows: addr 0 DATA (RO, debounced level), addr 1 reserved (reads 0, writes ignored), addr 2 IRQMASK (RW, WIDTH bits), addr 3 EDGECAP (read; write-1-to-clear per bit).
REQ-016 SHALL register readdata every clk, zero-extended from WIDTH bits: readdata <= value(address) on every cycle; read latency is 1 cycle; chipselect is not required for reads.
REQ-017 SHALL update IRQMASK <= writedata[WIDTH-1:0] on the clk edge where chipselect = 1, write_n = 0 and address = 2.
REQ-018 SHALL clear EDGECAP bit i on a write to addr 3 where writedata[i] = 1; bits with writedata[i] = 0 are unaffected.
REQ-019 SHALL detect an edge on bit i when deb_q[i] changes, qualified by EDGE_TYPE: rising is 0->1, falling is 1->0, any is either; a detected edge sets EDGECAP[i] in the next cycle.
REQ-020 SHALL give set priority when an edge set and a write-clear hit the same EDGECAP bit in the same cycle; the bit ends at 1.
REQ-021 SHALL drive irq = |(EDGECAP & IRQMASK) combinationally from registers, with no extra latency.
REQ-022 SHALL ignore writes to addr 0 and addr 1.
REQ-023 SHALL ignore writedata bits above WIDTH-1.

Reset
REQ-024 SHALL reset the following while reset_n = 0 at a clk edge: readdata = 0, IRQMASK = 0, EDGECAP = 0, irq = 0, debounce counters = 0, synchronizer and deb_q = IDLE_LEVEL replicated.
REQ-025 SHALL abandon any debounce in progress when reset is asserted mid-operation, and SHALL register no edge on the first cycle after reset release.

Configuration
REQ-026 SHALL, with macro MNIST_NN_KEY_PIO_DEBOUNCE_EN defined, apply per-bit debouncing: a 16-bit counter resets to 0 whenever sync_q[i] != deb_q[i] is false or the input toggles; deb_q[i] takes sync_q[i] after DEBOUNCE_CYCLES consecutive cycles of sync_q[i] != deb_q[i].
REQ-027 SHALL, without MNIST_NN_KEY_PIO_DEBOUNCE_EN, drive deb_q = sync_q with one register stage and instantiate no counters.

Structure
REQ-028 SHALL place the address constants ADDR_DATA, ADDR_IRQMASK and ADDR_EDGECAP and the EDGE_RISE/EDGE_FALL/EDGE_ANY constants in package mnist_nn_pio_pkg.
REQ-029 SHALL implement the per-bit debouncer as sub-module mnist_nn_key_debounce (synchronizer input to deb_q output), instantiated WIDTH times under a generate loop.

Verification
REQ-030 SHALL cover reset: hold reset_n = 0 for 3 cycles with in_port = 4'hF -> readdata = 0, irq = 0, and no EDGECAP set after release.
REQ-031 SHALL cover macro off, EDGE_TYPE = 1: drive in_port 4'hF->4'hE -> EDGECAP[0] = 1 within 4 cycles; with IRQMASK = 4'h1, irq = 1; write 32'h1 to addr 3 -> irq = 0 the next cycle.
REQ-032 SHALL cover macro on, DEBOUNCE_CYCLES = 8: bounce bit 1 at a 3-cycle period for 30 cycles, then hold 0 -> exactly one EDGECAP[1] set, occurring 8 cycles after the bouncing stops (plus synchronizer delay).
REQ-033 SHALL cover set-versus-clear collision: an edge on bit 2 in the same cycle as a write of 32'h4 to addr 3 -> EDGECAP[2] = 1.
REQ-034 SHALL cover read latency: with in_port = 4'h5 stable, address = 0 -> readdata = 32'h5 one cycle later; address = 1 -> readdata = 0; write 32'hFFFF_FFFF to addr 2 -> reading addr 2 returns 32'hF.
